// File: rtl/commit_unit.sv
// commit_unit: retires the ROB head, writing the register file or issuing a store and waiting for its ack.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
module commit_unit #(
  parameter int CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    commit_ready,
  input  logic                    commit_wr_mem,
  input  logic [4:0]              commit_dest_reg,
  input  logic [`XLEN-1:0]        commit_value,
  input  logic [`XLEN-1:0]        commit_dest_addr,
  input  logic [`ROB_TAG_LEN-1:0] commit_tag,
  input  logic                    mem_ack,
  output logic                    rob_pop,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [`XLEN-1:0]        rf_wdata,
  output logic                    clear_tag_valid,
  output logic [`ROB_TAG_LEN-1:0] clear_tag,
  output logic                    mem_req,
  output logic [`XLEN-1:0]        mem_addr,
  output logic [`XLEN-1:0]        mem_data,
  output logic [CNT_W-1:0]        retired_count,
  output logic                    busy
);
  typedef enum logic {IDLE, ST_WAIT} state_t;
  state_t state;
  logic reg_go, st_go, ack_go;
  always_comb begin
    reg_go  = state == IDLE && commit_ready && !commit_wr_mem;
    st_go   = state == IDLE && commit_ready && commit_wr_mem;
    ack_go  = state == ST_WAIT && mem_ack;
    rob_pop = reset && (reg_go || ack_go);
    busy    = state == ST_WAIT;
  end
  // The store's tag is parked in clear_tag while waiting; clear_tag_valid stays low until the ack.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      clear_tag_valid <= 1'b0;
      clear_tag       <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      mem_data        <= '0;
      retired_count   <= '0;
    end else begin
      rf_we           <= 1'b0;
      clear_tag_valid <= 1'b0;
      retired_count   <= retired_count + CNT_W'(rob_pop);
      if (reg_go) begin
        rf_we           <= commit_dest_reg != 5'd0;
        rf_waddr        <= commit_dest_reg;
        rf_wdata        <= commit_value;
        clear_tag_valid <= 1'b1;
        clear_tag       <= commit_tag;
      end
      if (st_go) begin
        state     <= ST_WAIT;
        mem_req   <= 1'b1;
        mem_addr  <= commit_dest_addr;
        mem_data  <= commit_value;
        clear_tag <= commit_tag;
      end
      if (ack_go) begin
        state           <= IDLE;
        mem_req         <= 1'b0;
        clear_tag_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: scoreboard bench; retirements queue expected writebacks, a negedge monitor checks them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
module tb_commit_unit;
  localparam int XL = `XLEN;
  localparam int TL = `ROB_TAG_LEN;
  typedef struct {
    logic          we;
    logic [4:0]    wa;
    logic [XL-1:0] wd;
    logic [TL-1:0] tag;
    logic [31:0]   cnt;
  } rec_t;
  logic clock = 0, reset = 0, commit_ready = 0, commit_wr_mem = 0, mem_ack = 0;
  logic [4:0] commit_dest_reg = 0;
  logic [XL-1:0] commit_value = 0, commit_dest_addr = 0;
  logic [TL-1:0] commit_tag = 0;
  logic rob_pop, rf_we, clear_tag_valid, mem_req, busy;
  logic [4:0] rf_waddr;
  logic [XL-1:0] rf_wdata, mem_addr, mem_data;
  logic [TL-1:0] clear_tag;
  logic [31:0] retired_count;
  logic w_pop, w_we, w_ctv, w_req, w_busy;
  logic [4:0] w_wa;
  logic [XL-1:0] w_wd, w_ma, w_md;
  logic [TL-1:0] w_ct;
  logic [3:0] w_cnt;
  commit_unit dut (
    .clock(clock), .reset(reset), .commit_ready(commit_ready), .commit_wr_mem(commit_wr_mem),
    .commit_dest_reg(commit_dest_reg), .commit_value(commit_value), .commit_dest_addr(commit_dest_addr),
    .commit_tag(commit_tag), .mem_ack(mem_ack), .rob_pop(rob_pop), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .clear_tag_valid(clear_tag_valid), .clear_tag(clear_tag), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .retired_count(retired_count), .busy(busy)
  );
  commit_unit #(.CNT_W(4)) u_w (
    .clock(clock), .reset(reset), .commit_ready(commit_ready), .commit_wr_mem(commit_wr_mem),
    .commit_dest_reg(commit_dest_reg), .commit_value(commit_value), .commit_dest_addr(commit_dest_addr),
    .commit_tag(commit_tag), .mem_ack(mem_ack), .rob_pop(w_pop), .rf_we(w_we), .rf_waddr(w_wa),
    .rf_wdata(w_wd), .clear_tag_valid(w_ctv), .clear_tag(w_ct), .mem_req(w_req),
    .mem_addr(w_ma), .mem_data(w_md), .retired_count(w_cnt), .busy(w_busy)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;
  rec_t q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clock) begin
    rec_t r;
    if (clear_tag_valid) begin
      if (q.size() == 0) chk("unexpected clear_tag_valid", 1, 0);
      else begin
        r = q.pop_front();
        chk("rf_we", rf_we, r.we);
        if (r.we) begin
          chk("rf_waddr", rf_waddr, r.wa);
          chk("rf_wdata", rf_wdata, r.wd);
        end
        chk("clear_tag", clear_tag, r.tag);
        chk("retired_count", retired_count, r.cnt);
      end
    end else if (rf_we) chk("rf_we without clear_tag_valid", 1, 0);
  end
  task automatic idle();
    @(negedge clock);
    chk("idle busy", busy, 0);
    chk("idle mem_req", mem_req, 0);
    commit_ready = 0; commit_wr_mem = 0; mem_ack = 0;
    #1 chk("idle rob_pop", rob_pop, 0);
  endtask
  task automatic reg_commit(input logic [4:0] d, input logic [XL-1:0] v, input logic [TL-1:0] t);
    @(negedge clock);
    chk("reg busy", busy, 0);
    chk("reg mem_req", mem_req, 0);
    commit_ready = 1; commit_wr_mem = 0; mem_ack = 0;
    commit_dest_reg = d; commit_value = v; commit_tag = t;
    #1 chk("reg rob_pop", rob_pop, 1);
    exp_cnt++;
    q.push_back('{we: d != 0, wa: d, wd: v, tag: t, cnt: exp_cnt});
  endtask
  task automatic store_start(input logic [XL-1:0] a, input logic [XL-1:0] v, input logic [TL-1:0] t);
    @(negedge clock);
    commit_ready = 1; commit_wr_mem = 1; mem_ack = 0;
    commit_dest_addr = a; commit_value = v; commit_tag = t; commit_dest_reg = 5'd3;
    #1 chk("store issue rob_pop", rob_pop, 0);
  endtask
  task automatic store(input logic [XL-1:0] a, input logic [XL-1:0] v, input logic [TL-1:0] t, input int d);
    store_start(a, v, t);
    for (int i = 1; i <= d; i++) begin
      @(negedge clock);
      chk("wait mem_req", mem_req, 1);
      chk("wait mem_addr", mem_addr, a);
      chk("wait mem_data", mem_data, v);
      chk("wait busy", busy, 1);
      commit_dest_addr = ~a; commit_value = ~v; commit_tag = t + 1'b1;
      mem_ack = (i == d);
      #1 chk("wait rob_pop", rob_pop, i == d);
    end
    exp_cnt++;
    q.push_back('{we: 1'b0, wa: 5'd0, wd: '0, tag: t, cnt: exp_cnt});
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 0; commit_ready = 1; commit_wr_mem = 0; mem_ack = 1; commit_dest_reg = 5'd9;
    #1 chk("reset rob_pop", rob_pop, 0);
    q.delete();
    exp_cnt = 0;
    @(negedge clock);
    chk("rst rf_we", rf_we, 0);
    chk("rst clear_tag_valid", clear_tag_valid, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst busy", busy, 0);
    chk("rst retired_count", retired_count, 0);
    chk("rst rf_waddr", rf_waddr, 0);
    chk("rst rf_wdata", rf_wdata, 0);
    chk("rst clear_tag", clear_tag, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_data", mem_data, 0);
    reset = 1; commit_ready = 0; mem_ack = 0;
  endtask
  initial begin
    do_reset();
    reg_commit(5'd5, 32'hDEADBEEF, 5'd2);
    idle();
    reg_commit(5'd0, 32'h1234, 5'd3);
    idle();
    store(32'h100, 32'h55, 5'd4, 3);
    idle();
    do_reset();
    for (int i = 1; i <= 4; i++) reg_commit(5'(i), 32'hA000 + i, 5'(i + 10));
    store(32'h200, 32'hAA, 5'd9, 1);
    reg_commit(5'd7, 32'hC0FFEE, 5'd15);
    idle();
    chk("b2b retired_count", retired_count, 6);
    store_start(32'h300, 32'h77, 5'd6);
    @(negedge clock);
    chk("mid-store mem_req", mem_req, 1);
    do_reset();
    @(negedge clock);
    commit_ready = 0; mem_ack = 1;
    #1 chk("idle ack rob_pop", rob_pop, 0);
    idle();
    chk("idle ack retired_count", retired_count, 0);
    for (int i = 0; i < 17; i++) reg_commit(5'(i % 31 + 1), 32'(i * 3), 5'(i));
    idle();
    chk("wrap retired_count cnt4", w_cnt, 1);
    chk("wrap retired_count cnt32", retired_count, 17);
    idle();
    chk("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
